bloco_controle: RTL and testbench

//  Control FSM that sits directly upstream of the datapath (blocoOperativo): it drives
//  LX, LH, LS, M0, M1, M2 and H so the datapath computes one of four expressions

---
 rtl/bloco_controle.sv | 125 ++++++++++++
 tb/tb_bloco_controle.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bloco_controle.sv
// Control FSM for blocoOperativo: sequences LX/LH/LS, M0/M1/M2 and H so the datapath evaluates one of four expressions.
// Optional macro CTRL_ACCUM_EN: op11 becomes the single-step accumulate S = S + A.
module bloco_controle #(
    parameter int unsigned DONE_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic       LX,
    output logic       LH,
    output logic       LS,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       H
);

    localparam int unsigned HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic [1:0]      op_q, op_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [1:0]      last_step;
    logic [9:0]      word;

    always_comb begin
        last_step = 2'd3;
        unique case (op_q)
            2'b00, 2'b01: last_step = 2'd3;
            2'b10:        last_step = 2'd2;
`ifdef CTRL_ACCUM_EN
            2'b11:        last_step = 2'd0;
`else
            2'b11:        last_step = 2'd1;
`endif
            default:      last_step = 2'd3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    step_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (step_q == last_step) begin
                    step_d  = '0;
                    hold_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (hold_q == HW'(DONE_HOLD - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            op_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            hold_q  <= hold_d;
        end
    end

    // Control word layout: M0 M1 M2 H LX LH LS; all-zero is the idle word.
    always_comb begin
        word = '0;
        if (state_q == ST_RUN) begin
            unique case ({op_q, step_q})
                4'b00_00, 4'b01_00: word = 10'b01_00_01_1_0_1_0;
                4'b00_01, 4'b01_01: word = 10'b01_00_11_0_0_1_0;
                4'b00_10, 4'b01_10: word = 10'b10_00_11_0_0_1_0;
                4'b00_11:           word = 10'b11_00_11_0_0_0_1;
                4'b01_11:           word = 10'b11_00_11_1_0_0_1;
                4'b10_00:           word = 10'b00_00_00_0_1_0_0;
                4'b10_01:           word = 10'b01_01_01_1_0_1_0;
                4'b10_10:           word = 10'b10_00_11_0_0_0_1;
`ifdef CTRL_ACCUM_EN
                4'b11_00:           word = 10'b01_00_10_0_0_0_1;
`else
                4'b11_00:           word = 10'b00_00_00_0_1_0_0;
                4'b11_01:           word = 10'b11_01_01_1_0_0_1;
`endif
                default:            word = '0;
            endcase
        end
    end

    assign {M0, M1, M2, H, LX, LH, LS} = word;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bloco_controle.sv
// Bench for bloco_controle: queue-based reference of expected control words plus a small datapath model.
module tb_bloco_controle;

    localparam int unsigned DH = 2;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] op;
    logic       busy, done, lx, lh, ls, h_op;
    logic [1:0] m0, m1, m2;

    logic [15:0] a_v, b_v, c_v, k_v;
    logic [15:0] x_dp, h_dp, s_dp;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [9:0]  w;
        logic [15:0] res;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [9:0]  prog [4][4];
    int unsigned plen [4];
    logic        was_idle;
    logic [15:0] res_v;

    always #5 clk = ~clk;

    bloco_controle #(.DONE_HOLD(DH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .LX    (lx),
        .LH    (lh),
        .LS    (ls),
        .M0    (m0),
        .M1    (m1),
        .M2    (m2),
        .H     (h_op)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // Microprograms as listed for each op (word = M0 M1 M2 H LX LH LS).
    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) prog[i][j] = '0;
        prog[0][0] = 10'b01_00_01_1_0_1_0;
        prog[0][1] = 10'b01_00_11_0_0_1_0;
        prog[0][2] = 10'b10_00_11_0_0_1_0;
        prog[0][3] = 10'b11_00_11_0_0_0_1;
        prog[1][0] = 10'b01_00_01_1_0_1_0;
        prog[1][1] = 10'b01_00_11_0_0_1_0;
        prog[1][2] = 10'b10_00_11_0_0_1_0;
        prog[1][3] = 10'b11_00_11_1_0_0_1;
        prog[2][0] = 10'b00_00_00_0_1_0_0;
        prog[2][1] = 10'b01_01_01_1_0_1_0;
        prog[2][2] = 10'b10_00_11_0_0_0_1;
        plen[0] = 4; plen[1] = 4; plen[2] = 3;
`ifdef CTRL_ACCUM_EN
        prog[3][0] = 10'b01_00_10_0_0_0_1;
        plen[3] = 1;
`else
        prog[3][0] = 10'b00_00_00_0_1_0_0;
        prog[3][1] = 10'b11_01_01_1_0_0_1;
        plen[3] = 2;
`endif
    end

    // Datapath model driven by the DUT's control word; outputs are stable mid-cycle.
    initial begin
        x_dp = '0; h_dp = '0; s_dp = '0;
    end
    always @(negedge clk) begin
        logic [15:0] mux0, opa, opb, ula;
        case (m0)
            2'b00: mux0 = k_v;
            2'b01: mux0 = a_v;
            2'b10: mux0 = b_v;
            default: mux0 = c_v;
        endcase
        case (m2)
            2'b00: opa = x_dp;
            2'b01: opa = mux0;
            2'b10: opa = s_dp;
            default: opa = h_dp;
        endcase
        case (m1)
            2'b00: opb = mux0;
            2'b01: opb = x_dp;
            2'b10: opb = s_dp;
            default: opb = h_dp;
        endcase
        ula = h_op ? (opa - opb) : (opa + opb);
        if (lx) x_dp = k_v;
        if (lh) h_dp = ula;
        if (ls) s_dp = ula;
    end

    // Reference: every accepted start enqueues its whole expected timeline.
    always @(posedge clk) begin
        was_idle = (q.size() == 0);
        if (!was_idle) void'(q.pop_front());
        if (rst) begin
            q.delete();
        end else if (was_idle && start) begin
            case (op)
                2'b00: res_v = a_v + b_v + c_v;
                2'b01: res_v = a_v + b_v - c_v;
                2'b10: res_v = a_v - k_v + b_v;
`ifdef CTRL_ACCUM_EN
                default: res_v = s_dp + a_v;
`else
                default: res_v = c_v - k_v;
`endif
            endcase
            for (int unsigned i = 0; i < plen[op]; i++)
                q.push_back('{busy: 1'b1, done: 1'b0, w: prog[op][i], res: res_v});
            for (int unsigned i = 0; i < DH; i++)
                q.push_back('{busy: 1'b1, done: 1'b1, w: 10'b0, res: res_v});
        end
        #1;
        e = (q.size() == 0) ? exp_t'('0) : q[0];
        check("ctrl", {20'b0, busy, done, m0, m1, m2, h_op, lx, lh, ls}, {20'b0, e.busy, e.done, e.w});
        if (e.done) check("resultado", {16'b0, s_dp}, {16'b0, e.res});
    end

    task automatic set_abck(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] k);
        a_v = a; b_v = b; c_v = c; k_v = k;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] exp_res, input int exp_lat, input string nm);
        int cnt;
        @(negedge clk); start = 1'b1; op = o;
        @(posedge clk); #1; start = 1'b0; cnt = 1;
        while (!done && cnt < 60) begin
            @(posedge clk); #1; cnt++;
        end
        check({nm, "_latency"}, cnt, exp_lat);
        check({nm, "_result"}, {16'b0, s_dp}, {16'b0, exp_res});
        wait_idle();
    endtask

    initial begin
        int cnt;
        logic prev;
        rst = 1'b1; start = 1'b0; op = 2'b00;
        set_abck(16'd5, 16'd7, 16'd3, 16'd2);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {20'b0, busy, done, m0, m1, m2, h_op, lx, lh, ls}, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op(2'b01, 16'd9,  5, "op01");
        run_op(2'b10, 16'd10, 4, "op10");
        run_op(2'b00, 16'd15, 5, "op00");
`ifdef CTRL_ACCUM_EN
        run_op(2'b11, 16'd20, 2, "op11_accum");
`else
        run_op(2'b11, 16'd1,  3, "op11");
        set_abck(16'd0, 16'd7, 16'd0, 16'd1);
        run_op(2'b11, 16'hFFFF, 3, "op11_wrap");
        set_abck(16'd5, 16'd7, 16'd3, 16'd2);
`endif

        // Reset during op00 step 2 aborts without a done pulse.
        @(negedge clk); start = 1'b1; op = 2'b00;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_outputs", {20'b0, busy, done, m0, m1, m2, h_op, lx, lh, ls}, 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("abort_no_done", cnt, 0);

        // Start held high: one done per run with an IDLE cycle between runs.
        @(negedge clk); start = 1'b1; op = 2'b00;
        cnt = 0; prev = 1'b0;
        repeat (2 * (5 + DH)) begin
            @(posedge clk); #1;
            if (done && !prev) cnt++;
            prev = done;
        end
        start = 1'b0;
        check("held_start_runs", cnt, 2);
        wait_idle();

        // op toggled while running must not alter the result.
        @(negedge clk); start = 1'b1; op = 2'b00;
        @(posedge clk); #1; start = 1'b0;
        cnt = 0;
        while (!done && cnt < 60) begin
            @(negedge clk); op = op + 2'd1;
            @(posedge clk); #1; cnt++;
        end
        check("op_toggle_result", {16'b0, s_dp}, 32'd15);
        wait_idle();

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 2'($urandom_range(0, 3));
            if (!busy) set_abck(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end
        @(negedge clk); rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
